// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM time-slot arbiter.
// Four clocks per pixel: slot V = ph0/ph1, slot H = ph2/ph3.
package sram_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 20;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned PH_W       = 2;

    localparam logic [PH_W-1:0] PH_V0 = 2'd0;
    localparam logic [PH_W-1:0] PH_V1 = 2'd1;
    localparam logic [PH_W-1:0] PH_H0 = 2'd2;
    localparam logic [PH_W-1:0] PH_H1 = 2'd3;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_HRD  = 2'd2,
        OWN_HWR  = 2'd3
    } owner_t;

    // Owner code for a granted host transaction
    function automatic owner_t host_owner(input logic we);
        return we ? OWN_HWR : OWN_HRD;
    endfunction

endpackage

// File: rtl/sram_slot_timer.sv
// Free-running pixel phase counter with strobes flagging the edge that
// starts the next video slot or host slot.
module sram_slot_timer
    import sram_arb_pkg::*;
(
    input  logic sramclk,
    input  logic rst,
    output logic o_v_start_c,
    output logic o_h_start_c
);

    logic [PH_W-1:0] r_ph;

    always_ff @(posedge sramclk) begin
        if (rst) begin
            r_ph <= PH_V0;
        end else begin
            r_ph <= r_ph + PH_W'(1);
        end
    end

    // The coming edge enters ph0 / ph2 respectively
    assign o_v_start_c = (r_ph == PH_H1);
    assign o_h_start_c = (r_ph == PH_V1);

endmodule

// File: rtl/sram_slot_arbiter.sv
// Shares one asynchronous SRAM between the video fetcher and a host port
// using fixed two-cycle slots; idle video slots are lent to the host.
module sram_slot_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              sramclk,
    input  logic              rst,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_din,
    output logic [DATA_W-1:0] host_dout,
    output logic              host_ack,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_we_n
);

    logic              w_v_start;
    logic              w_h_start;
    logic              w_decide;
    logic              w_host_ok;
    owner_t            r_owner;
    owner_t            w_owner_nxt;

    logic [ADDR_W-1:0] r_addr;
    logic              r_we_n;
    logic              r_drive;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_vid_data;
    logic              r_vid_valid;
    logic [DATA_W-1:0] r_host_dout;
    logic              r_host_ack;

    sram_slot_timer u_timer (
        .sramclk     (sramclk),
        .rst         (rst),
        .o_v_start_c (w_v_start),
        .o_h_start_c (w_h_start)
    );

    assign w_decide = w_v_start | w_h_start;

    // A host slot ending at this edge raises host_ack now, so its request
    // is still visible and must not be granted a second time.
    assign w_host_ok = host_req && (r_owner != OWN_HRD) && (r_owner != OWN_HWR);

    always_ff @(posedge sramclk) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    always_comb begin
        w_owner_nxt = r_owner;
        if (w_v_start) begin
            if (vid_req) begin
                w_owner_nxt = OWN_VID;
            end else if (w_host_ok) begin
                w_owner_nxt = host_owner(host_we);
            end else begin
                w_owner_nxt = OWN_NONE;
            end
        end else if (w_h_start) begin
            if (w_host_ok) begin
                w_owner_nxt = host_owner(host_we);
            end else begin
                w_owner_nxt = OWN_NONE;
            end
        end
    end

    // Pin registers, completion pulses and read capture
    always_ff @(posedge sramclk) begin
        if (rst) begin
            r_addr      <= '0;
            r_we_n      <= 1'b1;
            r_drive     <= 1'b0;
            r_wdata     <= '0;
            r_vid_data  <= '0;
            r_vid_valid <= 1'b0;
            r_host_dout <= '0;
            r_host_ack  <= 1'b0;
        end else begin
            r_vid_valid <= 1'b0;
            r_host_ack  <= 1'b0;
            r_we_n      <= 1'b1;
            if (w_decide) begin
                case (r_owner)
                    OWN_VID: begin
                        r_vid_data  <= sram_data;
                        r_vid_valid <= 1'b1;
                    end
                    OWN_HRD: begin
                        r_host_dout <= sram_data;
                        r_host_ack  <= 1'b1;
                    end
                    OWN_HWR: begin
                        r_host_ack  <= 1'b1;
                    end
                    default: begin
                    end
                endcase
                r_drive <= (w_owner_nxt == OWN_HWR);
                if (w_owner_nxt == OWN_VID) begin
                    r_addr <= vid_addr;
                end else if (w_owner_nxt != OWN_NONE) begin
                    r_addr <= host_addr;
                end
                if (w_owner_nxt == OWN_HWR) begin
                    r_wdata <= host_din;
                end
            end else begin
                // Mid-slot edge: strobe write enable for the second cycle only
                r_we_n <= (r_owner != OWN_HWR);
            end
        end
    end

    assign sram_data = r_drive ? r_wdata : {DATA_W{1'bz}};
    assign sram_addr = r_addr;
    assign sram_we_n = r_we_n;
    assign vid_data  = r_vid_data;
    assign vid_valid = r_vid_valid;
    assign host_dout = r_host_dout;
    assign host_ack  = r_host_ack;

endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Scoreboard bench for sram_slot_arbiter with a behavioural async SRAM that
// drives read data in the second cycle of each slot.
module tb_sram_slot_arbiter;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 8;

    logic          sramclk = 1'b0;
    logic          rst;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_din;
    logic [DW-1:0] host_dout;
    logic          host_ack;
    logic [AW-1:0] sram_addr;
    wire  [DW-1:0] sram_data;
    logic          sram_we_n;

    sram_slot_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .sramclk   (sramclk),
        .rst       (rst),
        .vid_req   (vid_req),
        .vid_addr  (vid_addr),
        .vid_data  (vid_data),
        .vid_valid (vid_valid),
        .host_req  (host_req),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_din  (host_din),
        .host_dout (host_dout),
        .host_ack  (host_ack),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_we_n (sram_we_n)
    );

    always #5 sramclk = ~sramclk;

    typedef struct {
        logic [7:0] data;
        int         ph;
        bit         chk_data;
    } exp_t;

    logic [7:0] mem [0:(1<<20)-1];
    logic [7:0] refm [0:15];
    logic [1:0] tb_ph = 2'd0;
    exp_t       vid_q[$];
    exp_t       host_q[$];
    exp_t       mon_e;
    int         n_vec  = 0;
    int         n_miss = 0;

    // Reference pixel phase: ph0 is the first cycle after reset
    always @(posedge sramclk) begin
        if (rst) tb_ph <= 2'd0;
        else     tb_ph <= tb_ph + 2'd1;
    end

    always @(posedge sramclk) begin
        if (!sram_we_n) mem[sram_addr] <= sram_data;
    end

    assign sram_data = (tb_ph[0] && sram_we_n) ? mem[sram_addr] : 8'bz;

    function automatic exp_t mk(input logic [7:0] d, input int p, input bit c);
        exp_t t;
        t.data     = d;
        t.ph       = p;
        t.chk_data = c;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ph(input logic [1:0] p);
        for (int i = 0; i < 8; i++) begin
            @(negedge sramclk);
            if (tb_ph == p) return;
        end
        n_vec++;
        n_miss++;
        $display("FAIL wait_ph: phase %0d not reached", p);
    endtask

    task automatic vid_read(input logic [AW-1:0] a, input logic [7:0] d);
        wait_ph(2'd3);
        vid_req  = 1'b1;
        vid_addr = a;
        vid_q.push_back(mk(d, 2, 1'b1));
        wait_ph(2'd0);
        chk("vid_addr_ph0", 32'(sram_addr), 32'(a));
        wait_ph(2'd1);
        chk("vid_addr_ph1", 32'(sram_addr), 32'(a));
        chk("vid_we_n", 32'(sram_we_n), 32'd1);
        vid_req = 1'b0;
    endtask

    // Monitor: every completion pulse must match the oldest pending expectation
    always @(negedge sramclk) begin
        if (!rst) begin
            if (vid_valid) begin
                if (vid_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL vid_valid_spurious: data 0x%0h at ph%0d, none pending", vid_data, tb_ph);
                end else begin
                    mon_e = vid_q.pop_front();
                    chk("vid_data", 32'(vid_data), 32'(mon_e.data));
                    chk("vid_valid_ph", 32'(tb_ph), 32'(mon_e.ph));
                end
            end
            if (host_ack) begin
                if (host_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL host_ack_spurious: ack at ph%0d, none pending", tb_ph);
                end else begin
                    mon_e = host_q.pop_front();
                    if (mon_e.chk_data) chk("host_dout", 32'(host_dout), 32'(mon_e.data));
                    chk("host_ack_ph", 32'(tb_ph), 32'(mon_e.ph));
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; vid_req = 1'b0; vid_addr = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_din = '0;
        mem[20'h00010] = 8'hA5;
        mem[20'h00011] = 8'h5A;
        mem[20'h00012] = 8'hC3;
        for (int i = 0; i < 16; i++) begin
            mem[20'h20 + 20'(i)] = 8'(i * 29 + 7);
            mem[20'h40 + 20'(i)] = 8'h00;
            refm[i] = 8'h00;
        end

        repeat (3) @(negedge sramclk);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_vid_valid", 32'(vid_valid), 32'd0);
        chk("rst_host_ack", 32'(host_ack), 32'd0);
        chk("rst_vid_data", 32'(vid_data), 32'd0);
        chk("rst_host_dout", 32'(host_dout), 32'd0);
        rst = 1'b0;

        // Back-to-back video reads, one per pixel
        vid_read(20'h00010, 8'hA5);
        vid_read(20'h00011, 8'h5A);
        vid_read(20'h00012, 8'hC3);

        // Host write while video busy: lands in slot H
        wait_ph(2'd3);
        vid_req = 1'b1; vid_addr = 20'h00010;
        host_req = 1'b1; host_we = 1'b1; host_addr = 20'h12345; host_din = 8'h3C;
        vid_q.push_back(mk(8'hA5, 2, 1'b1));
        host_q.push_back(mk(8'h00, 0, 1'b0));
        wait_ph(2'd0);
        chk("wr_vid_addr", 32'(sram_addr), 32'h10);
        wait_ph(2'd1);
        vid_req = 1'b0;
        wait_ph(2'd2);
        chk("wr_addr_ph2", 32'(sram_addr), 32'h12345);
        chk("wr_we_n_ph2", 32'(sram_we_n), 32'd1);
        chk("wr_data_ph2", 32'(sram_data), 32'h3C);
        wait_ph(2'd3);
        chk("wr_we_n_ph3", 32'(sram_we_n), 32'd0);
        chk("wr_data_ph3", 32'(sram_data), 32'h3C);
        wait_ph(2'd0);
        chk("wr_we_n_ph0", 32'(sram_we_n), 32'd1);
        chk("wr_mem", 32'(mem[20'h12345]), 32'h3C);
        host_req = 1'b0; host_we = 1'b0;
        wait_ph(2'd1);
        chk("idle_addr_hold", 32'(sram_addr), 32'h12345);
        chk("idle_we_n", 32'(sram_we_n), 32'd1);

        // Host read borrows idle slot V; request still high at the ack edge
        wait_ph(2'd3);
        host_req = 1'b1; host_we = 1'b0; host_addr = 20'h12345;
        host_q.push_back(mk(8'h3C, 2, 1'b1));
        wait_ph(2'd0);
        chk("hrd_addr_ph0", 32'(sram_addr), 32'h12345);
        chk("hrd_we_n", 32'(sram_we_n), 32'd1);
        wait_ph(2'd2);
        host_req = 1'b0;
        wait_ph(2'd3);
        chk("mask_we_n", 32'(sram_we_n), 32'd1);

        // Simultaneous requests: video in slot V, host in slot H
        wait_ph(2'd3);
        vid_req = 1'b1; vid_addr = 20'h00011;
        host_req = 1'b1; host_we = 1'b0; host_addr = 20'h00010;
        vid_q.push_back(mk(8'h5A, 2, 1'b1));
        host_q.push_back(mk(8'hA5, 0, 1'b1));
        wait_ph(2'd0);
        chk("both_vid_addr", 32'(sram_addr), 32'h11);
        wait_ph(2'd1);
        vid_req = 1'b0;
        wait_ph(2'd2);
        chk("both_host_addr", 32'(sram_addr), 32'h10);
        wait_ph(2'd0);
        host_req = 1'b0;

        // Reset in the strobe cycle of a host write
        wait_ph(2'd1);
        host_req = 1'b1; host_we = 1'b1; host_addr = 20'h00ABC; host_din = 8'h77;
        wait_ph(2'd2);
        chk("rstwr_addr", 32'(sram_addr), 32'hABC);
        wait_ph(2'd3);
        chk("rstwr_we_n_low", 32'(sram_we_n), 32'd0);
        rst = 1'b1; host_req = 1'b0;
        @(negedge sramclk);
        chk("rstwr_we_n", 32'(sram_we_n), 32'd1);
        chk("rstwr_no_ack", 32'(host_ack), 32'd0);
        chk("rstwr_addr_clr", 32'(sram_addr), 32'd0);
        @(negedge sramclk);
        rst = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 20'h12345;
        host_q.push_back(mk(8'h3C, 0, 1'b1));
        wait_ph(2'd1);
        chk("post_rst_no_grant", 32'(sram_addr), 32'd0);
        wait_ph(2'd2);
        chk("post_rst_grant", 32'(sram_addr), 32'h12345);
        wait_ph(2'd0);
        host_req = 1'b0;

        // Randomised mix against the reference memory
        for (int it = 0; it < 40; it++) begin
            logic       dv;
            logic       dh;
            logic       we;
            logic [3:0] va;
            logic [3:0] ha;
            dv = 1'($urandom_range(0, 1));
            dh = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            va = 4'($urandom_range(0, 15));
            ha = 4'($urandom_range(0, 15));
            wait_ph(2'd3);
            if (dv) begin
                vid_req  = 1'b1;
                vid_addr = 20'h20 + 20'(va);
                vid_q.push_back(mk(8'(va * 29 + 7), 2, 1'b1));
            end
            if (dh) begin
                host_req  = 1'b1;
                host_we   = we;
                host_addr = 20'h40 + 20'(ha);
                host_din  = 8'($urandom);
                if (we) begin
                    refm[ha] = host_din;
                    host_q.push_back(mk(8'h00, dv ? 0 : 2, 1'b0));
                end else begin
                    host_q.push_back(mk(refm[ha], dv ? 0 : 2, 1'b1));
                end
            end
            for (int c = 0; c < 12; c++) begin
                if (!vid_req && !host_req) break;
                @(negedge sramclk);
                if (vid_req && tb_ph == 2'd1) vid_req = 1'b0;
                if (host_req && host_ack) host_req = 1'b0;
            end
            if (vid_req || host_req) begin
                n_vec++;
                n_miss++;
                $display("FAIL rand_timeout: iteration %0d vid_req=%0b host_req=%0b", it, vid_req, host_req);
                vid_req  = 1'b0;
                host_req = 1'b0;
            end
        end

        repeat (8) @(negedge sramclk);
        chk("vid_q_drained", 32'(vid_q.size()), 32'd0);
        chk("host_q_drained", 32'(host_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sram_slot_arbiter.md
# sram_slot_arbiter

Time-slot controller that shares the single 8-bit asynchronous SRAM between the video fetcher and one host port (CPU or pattern writer), replacing ad-hoc dual-port emulation. It runs in the 28 MHz SRAM clock domain: 4 clocks per 7 MHz pixel, giving one video slot and one host slot per pixel. Idle video slots are lent to the host. It owns the SRAM pins directly and sits between the video/host logic and the top-level pads.

## Interface
Parameters:
- ADDR_W, 20, SRAM address width
- DATA_W, 8, SRAM data width

Ports:
- sramclk  in  1  28 MHz clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- vid_req  in  1  level; video wants a read in the next video slot
- vid_addr  in  ADDR_W  video read address, held until vid_valid
- vid_data  out  DATA_W  video read data, valid while vid_valid
- vid_valid  out  1  one-cycle pulse, read complete
- host_req  in  1  level; host transaction pending, held until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_din  in  DATA_W  host write data
- host_dout  out  DATA_W  host read data, valid while host_ack (reads)
- host_ack  out  1  one-cycle pulse, transaction complete
- sram_addr  out  ADDR_W  SRAM address, registered
- sram_data  inout  DATA_W  SRAM data bus, driven only during host writes
- sram_we_n  out  1  SRAM write strobe, registered, active low

## Operation
- 2-bit phase counter ph, free-running 0,1,2,3,0… Slot V = ph0–ph1, slot H = ph2–ph3.
- Owner decision is registered at the edge entering ph0 (slot V) and the edge entering ph2 (slot H). Owner is held for both cycles of the slot.
- Slot V:
  - vid_req=1 → video read.
  - Else host_req=1 (unmasked) → host op.
  - Else idle.
- Slot H:
  - host_req=1 (unmasked) → host op.
  - Else idle. Video never uses slot H.
- Read slot:
  - sram_addr drives the requester address for both cycles; bus is hi-Z.
  - Data is captured at the edge ending the slot into vid_data or host_dout.
- Write slot:
  - sram_addr and sram_data are driven for both cycles.
  - sram_we_n is low in the second cycle only.
  - The bus is released at the edge ending the slot.
- Completion:
  - vid_valid or host_ack is high for exactly the first cycle of the following slot.
  - vid_data and host_dout hold their value until the next capture.
- One outstanding host transaction. host_req is masked at any decision edge where host_ack is being asserted, so there is no double issue after an opportunistic slot-V grant.
- Idle slot: sram_addr keeps its previous value, sram_we_n=1, bus hi-Z.
- Address/data widths pass straight through; no arithmetic on addresses.

## Timing
- Reset values:
  - ph=0, sram_addr=0, sram_we_n=1, bus hi-Z.
  - vid_data=0, host_dout=0, vid_valid=0, host_ack=0.
  - Owner=none.
- After rst falls, the first cycle is ph0 with owner none. The first grant is possible at the edge entering ph2.
- Video latency: vid_req seen at the ph0 edge → vid_valid during ph2 (2 cycles). Sustained throughput is 1 byte per 4 clocks.
- Host latency:
  - Best case: 2 cycles after the decision edge.
  - Worst case with video busy: host_req raised just after the ph2 edge → ack 6 cycles later.
- Host must hold addr/din/we stable from req assertion until ack. Changes before ack are undefined.
- Host must drop host_req, or present a new transaction, no later than the cycle after ack.
- Simultaneous vid_req and host_req at the ph0 edge: video wins; host goes in the following slot H.
- Reset mid-slot:
  - Transaction is aborted and sram_we_n is forced high at the reset edge.
  - Bus is released and no ack/valid is generated.
  - Requesters must reissue.

## Structure
- Package sram_arb_pkg:
  - Phase constants PH_V0, PH_V1, PH_H0, PH_H1.
  - Owner enum OWN_NONE, OWN_VID, OWN_HRD, OWN_HWR.
  - Default ADDR_W, DATA_W.
- Sub-module sram_slot_timer: phase counter plus slot-start strobes (v_start, h_start). Everything else, including grant logic, pin registers and capture, lives in sram_slot_arbiter.

## Test plan
- Reset, then vid_req=1, vid_addr=0x00010, SRAM model returns 0xA5 → sram_addr=0x00010 in ph0/ph1, vid_valid in ph2 with vid_data=0xA5; one read every 4 clocks while held.
- Host write 0x3C to 0x12345 with vid_req=1 → write issued in slot H, sram_we_n low only in ph3, data driven ph2–ph3, host_ack in next ph0; model contains 0x3C.
- vid_req=0, host read of 0x12345 → granted in slot V, host_ack in ph2 with host_dout=0x3C; no second access in the same slot H (mask check).
- vid_req and host_req both rise before the ph0 edge → video in slot V, host in slot H; vid_valid at ph2, host_ack at ph0.
- rst asserted during ph3 of a host write → sram_we_n=1 at the next edge, bus hi-Z, no host_ack, ph=0 after reset.
- Randomised long run against a reference memory model → all video and host reads match; no ack without a completed slot.
